// File: rtl/fp32_div_seq_pkg.sv
// Shared constants and types for the sequential FP32 divider.
package fp32_div_seq_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned QBITS  = MANT_W + 2;
   localparam int unsigned CNT_W  = $clog2(QBITS);

   localparam logic [EXP_W-1:0] INF_EXP  = '1;
   localparam logic [30:0]      ZERO_MAG = '0;

   typedef enum logic [1:0] {StIdle, StCalc, StPack} state_e;

endpackage

// File: rtl/fp32_mant_div_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, MSB first.
module fp32_mant_div_iter
   import fp32_div_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [MANT_W-1:0] a_mant,
   input  logic [MANT_W-1:0] b_mant,
   output logic [QBITS-1:0]  q,
   output logic              last
);

   // rem stays below 2*div, so one guard bit above the divisor width suffices
   logic [MANT_W+1:0] rem_q, rem_d;
   logic [MANT_W:0]   div_q, div_d;
   logic [MANT_W:0]   diff;
   logic [QBITS-1:0]  q_q, q_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ge;

   always_comb begin
      ge    = rem_q >= {1'b0, div_q};
      diff  = rem_q[MANT_W:0] - div_q;
      rem_d = rem_q;
      div_d = div_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load) begin
         rem_d = {1'b0, 1'b1, a_mant};
         div_d = {1'b1, b_mant};
         q_d   = '0;
         cnt_d = CNT_W'(QBITS - 1);
      end else if (step) begin
         rem_d = ge ? {diff, 1'b0} : {rem_q[MANT_W:0], 1'b0};
         q_d   = {q_q[QBITS-2:0], ge};
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         div_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         div_q <= div_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q    = q_q;
   assign last = (cnt_q == '0);

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential truncating FP32 divider with start/done handshake and multiplier-style flags.
module fp32_div_seq
   import fp32_div_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        Exception,
   output logic        Overflow,
   output logic        Underflow,
   output logic        DivByZero
);

   state_e state_q, state_d;

   logic [EXP_W-1:0] a_exp, b_exp, ea_q, eb_q;
   logic             a_zero, b_zero, a_inf, b_inf, special;
   logic             sign_q, exc_q, a_zero_q, b_zero_q;
   logic             load, step, last, accept;
   logic [QBITS-1:0] q;

   logic signed [9:0] exp_s;
   logic [MANT_W-1:0] mant;
   logic [31:0]       result_q, result_d;
   logic [3:0]        flags_q, flags_d;
   logic              done_q;

   assign a_exp   = a_operand[MANT_W +: EXP_W];
   assign b_exp   = b_operand[MANT_W +: EXP_W];
   assign a_zero  = (a_exp == '0);
   assign b_zero  = (b_exp == '0);
   assign a_inf   = (a_exp == INF_EXP);
   assign b_inf   = (b_exp == INF_EXP);
   assign special = a_inf | b_inf | a_zero | b_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = special ? StPack : StCalc;
         StCalc: if (last)  state_d = StPack;
         StPack: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy   = (state_q != StIdle);
      accept = (state_q == StIdle) && start;
      load   = accept && !special;
      step   = (state_q == StCalc);
   end

   fp32_mant_div_iter u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .a_mant (a_operand[MANT_W-1:0]),
      .b_mant (b_operand[MANT_W-1:0]),
      .q      (q),
      .last   (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q   <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         exc_q    <= 1'b0;
         a_zero_q <= 1'b0;
         b_zero_q <= 1'b0;
      end else if (accept) begin
         sign_q   <= a_operand[31] ^ b_operand[31];
         ea_q     <= a_exp;
         eb_q     <= b_exp;
         exc_q    <= a_inf | b_inf;
         a_zero_q <= a_zero;
         b_zero_q <= b_zero;
      end
   end

   // A quotient below 1.0 leaves q[24] clear and costs one exponent step
   always_comb begin
      exp_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(10'(BIAS))
              - $signed({9'd0, ~q[QBITS-1]});
      mant  = q[QBITS-1] ? q[QBITS-2:1] : q[MANT_W-1:0];
   end

   // flags_d = {Exception, Overflow, Underflow, DivByZero}
   always_comb begin
      flags_d  = 4'b0000;
      result_d = {sign_q, exp_s[EXP_W-1:0], mant};
      if (exc_q) begin
         flags_d  = 4'b1000;
         result_d = '0;
      end else if (a_zero_q) begin
         result_d = {sign_q, ZERO_MAG};
      end else if (b_zero_q) begin
         flags_d  = 4'b0001;
         result_d = {sign_q, INF_EXP, {MANT_W{1'b0}}};
      end else if (exp_s >= 10'sd255) begin
         flags_d  = 4'b0100;
         result_d = {sign_q, INF_EXP, {MANT_W{1'b0}}};
      end else if (exp_s <= 10'sd0) begin
         flags_d  = 4'b0010;
         result_d = {sign_q, ZERO_MAG};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == StPack);
         if (state_q == StPack) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

   assign done      = done_q;
   assign result    = result_q;
   assign Exception = flags_q[3];
   assign Overflow  = flags_q[2];
   assign Underflow = flags_q[1];
   assign DivByZero = flags_q[0];

endmodule
